// File: rtl/pb_mesh_edge_sink.sv
// pb_mesh_edge_sink: absorbs flits arriving on mesh-boundary ports, counting drops per direction.
// Optional first-dropped-flit capture is built when PB_EDGE_SINK_HDR_CAPTURE_EN is defined.
module pb_mesh_edge_sink #(
    parameter int NumXMesh  = 3,
    parameter int NumYMesh  = 2,
    parameter int NumChan   = 3,
    parameter int FlitWidth = 64,
    parameter int CntWidth  = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [(NumXMesh > 1 ? $clog2(NumXMesh) : 1)-1:0] id_x_i,
    input  logic [(NumYMesh > 1 ? $clog2(NumYMesh) : 1)-1:0] id_y_i,
    input  logic [4*NumChan-1:0]              valid_i,
    output logic [4*NumChan-1:0]              ready_o,
    input  logic [4*NumChan*FlitWidth-1:0]    flit_i,
    input  logic                              clear_i,
    output logic [4*CntWidth-1:0]             cnt_o,
    output logic [3:0]                        err_dir_o,
    output logic                              irq_o,
    output logic [FlitWidth-1:0]              hdr_o,
    output logic [1:0]                        hdr_dir_o,
    output logic                              hdr_vld_o
);
    localparam int XW = NumXMesh > 1 ? $clog2(NumXMesh) : 1;
    localparam int YW = NumYMesh > 1 ? $clog2(NumYMesh) : 1;
    logic [3:0]              tie;
    logic [4*NumChan-1:0]    fire;
    logic [4*CntWidth-1:0]   cnt_q, cnt_d;
    logic [3:0]              err_q, err_d;
    logic [CntWidth:0]       pc, sum;
    // Direction bit order: North=0, East=1, South=2, West=3
    always_comb begin
        tie = {id_x_i == '0, id_y_i == '0, id_x_i == XW'(NumXMesh-1), id_y_i == YW'(NumYMesh-1)};
        for (int i = 0; i < 4*NumChan; i++) ready_o[i] = rst_ni & tie[i/NumChan];
        fire = valid_i & ready_o;
    end
    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        pc    = '0;
        sum   = '0;
        for (int d = 0; d < 4; d++) begin
            pc = '0;
            for (int c = 0; c < NumChan; c++) pc = pc + (CntWidth+1)'(fire[d*NumChan+c]);
            sum = {1'b0, cnt_q[d*CntWidth +: CntWidth]} + pc;
            cnt_d[d*CntWidth +: CntWidth] = sum[CntWidth] ? '1 : sum[CntWidth-1:0];
            err_d[d] = err_q[d] | (|fire[d*NumChan +: NumChan]);
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            cnt_q <= '0;
            err_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign cnt_o     = cnt_q;
    assign err_dir_o = err_q;
    assign irq_o     = |err_q;
`ifdef PB_EDGE_SINK_HDR_CAPTURE_EN
    logic [FlitWidth-1:0] hdr_q, hdr_d;
    logic [1:0]           hdr_dir_q, hdr_dir_d;
    logic                 hdr_vld_q, hdr_vld_d;
    // Scan from the top so the lowest-indexed fired lane wins
    always_comb begin
        hdr_d     = hdr_q;
        hdr_dir_d = hdr_dir_q;
        hdr_vld_d = hdr_vld_q;
        if (!hdr_vld_q) begin
            for (int i = 4*NumChan-1; i >= 0; i--) begin
                if (fire[i]) begin
                    hdr_d     = flit_i[i*FlitWidth +: FlitWidth];
                    hdr_dir_d = 2'(i/NumChan);
                    hdr_vld_d = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni || clear_i) begin
            hdr_q     <= '0;
            hdr_dir_q <= '0;
            hdr_vld_q <= 1'b0;
        end else begin
            hdr_q     <= hdr_d;
            hdr_dir_q <= hdr_dir_d;
            hdr_vld_q <= hdr_vld_d;
        end
    end
    assign hdr_o     = hdr_q;
    assign hdr_dir_o = hdr_dir_q;
    assign hdr_vld_o = hdr_vld_q;
`else
    assign hdr_o     = '0;
    assign hdr_dir_o = '0;
    assign hdr_vld_o = 1'b0;
`endif
endmodule

// File: tb/tb_pb_mesh_edge_sink.sv
// tb_pb_mesh_edge_sink: directed checks of the edge sink (16-bit and 4-bit counter builds side by side).
module tb_pb_mesh_edge_sink;
    localparam int NC = 3;
    localparam int FW = 64;
    localparam int CW = 16;
    logic             clk = 1'b0;
    logic             rst_ni;
    logic [1:0]       id_x;
    logic [0:0]       id_y;
    logic [4*NC-1:0]  valid, ready, ready4;
    logic [4*NC*FW-1:0] flit;
    logic             clear;
    logic [4*CW-1:0]  cnt;
    logic [15:0]      cnt4;
    logic [3:0]       err, err4;
    logic             irq, irq4;
    logic [FW-1:0]    hdr, hdr4;
    logic [1:0]       hdr_dir, hdr_dir4;
    logic             hdr_vld, hdr_vld4;
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pb_mesh_edge_sink dut (
        .clk_i(clk), .rst_ni(rst_ni), .id_x_i(id_x), .id_y_i(id_y),
        .valid_i(valid), .ready_o(ready), .flit_i(flit), .clear_i(clear),
        .cnt_o(cnt), .err_dir_o(err), .irq_o(irq),
        .hdr_o(hdr), .hdr_dir_o(hdr_dir), .hdr_vld_o(hdr_vld)
    );

    pb_mesh_edge_sink #(.CntWidth(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_ni), .id_x_i(id_x), .id_y_i(id_y),
        .valid_i(valid), .ready_o(ready4), .flit_i(flit), .clear_i(clear),
        .cnt_o(cnt4), .err_dir_o(err4), .irq_o(irq4),
        .hdr_o(hdr4), .hdr_dir_o(hdr_dir4), .hdr_vld_o(hdr_vld4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; id_x = 2'd0; id_y = 1'd0; valid = '1;
        tick(); tick();
        n_cmp++; if (ready !== '0) begin n_bad++; $display("FAIL rst_ready got %h want 000", ready); end
        n_cmp++; if (cnt !== '0) begin n_bad++; $display("FAIL rst_cnt got %h want 0", cnt); end
        n_cmp++; if (err !== 4'b0 || irq !== 1'b0) begin n_bad++; $display("FAIL rst_err got err=%b irq=%b want 0/0", err, irq); end
        n_cmp++; if (hdr_vld !== 1'b0 || hdr !== '0 || hdr_dir !== 2'd0) begin n_bad++; $display("FAIL rst_hdr got vld=%b hdr=%h dir=%0d want zeros", hdr_vld, hdr, hdr_dir); end
        valid = '0; rst_ni = 1'b1;
        tick();
    endtask

    task automatic test_corner00();
        id_x = 2'd0; id_y = 1'd0; #1;
        n_cmp++; if (ready !== 12'hFC0) begin n_bad++; $display("FAIL c00_ready got %h want fc0", ready); end
        valid = 12'h200;
        tick();
        n_cmp++; if (irq !== 1'b1 || err !== 4'b1000) begin n_bad++; $display("FAIL c00_irq got irq=%b err=%b want 1/1000", irq, err); end
        n_cmp++; if (cnt[3*CW +: CW] !== 16'd1) begin n_bad++; $display("FAIL c00_cnt1 got %0d want 1", cnt[3*CW +: CW]); end
        repeat (4) tick();
        valid = '0;
        n_cmp++; if (cnt !== {16'd5, 48'd0}) begin n_bad++; $display("FAIL c00_cnt5 got %h want 0005_0000_0000_0000", cnt); end
    endtask

    task automatic test_mid();
        pulse_clear();
        id_x = 2'd1; id_y = 1'd0; #1;
        n_cmp++; if (ready !== 12'h1C0) begin n_bad++; $display("FAIL mid_ready got %h want 1c0", ready); end
        valid = 12'h010;
        repeat (4) tick();
        valid = '0;
        n_cmp++; if (cnt !== '0 || err !== 4'b0 || irq !== 1'b0) begin n_bad++; $display("FAIL mid_ignore got cnt=%h err=%b irq=%b want 0", cnt, err, irq); end
    endtask

    task automatic test_north();
        pulse_clear();
        id_x = 2'd2; id_y = 1'd1; #1;
        n_cmp++; if (ready !== 12'h03F) begin n_bad++; $display("FAIL north_ready got %h want 03f", ready); end
        valid = 12'h007;
        tick();
        valid = '0;
        n_cmp++; if (cnt[0 +: CW] !== 16'd3 || err !== 4'b0001) begin n_bad++; $display("FAIL north_cnt got %0d err=%b want 3/0001", cnt[0 +: CW], err); end
        tick();
        n_cmp++; if (cnt[0 +: CW] !== 16'd3) begin n_bad++; $display("FAIL north_hold got %0d want 3", cnt[0 +: CW]); end
    endtask

    task automatic test_saturate();
        pulse_clear();
        id_x = 2'd2; id_y = 1'd1;
        valid = 12'h001;
        repeat (16) tick();
        n_cmp++; if (cnt4[3:0] !== 4'd15) begin n_bad++; $display("FAIL sat16 got %0d want 15", cnt4[3:0]); end
        repeat (4) tick();
        valid = '0;
        n_cmp++; if (cnt4[3:0] !== 4'd15 || err4 !== 4'b0001) begin n_bad++; $display("FAIL sat20 got %0d err=%b want 15/0001", cnt4[3:0], err4); end
        n_cmp++; if (cnt[0 +: CW] !== 16'd20) begin n_bad++; $display("FAIL wide20 got %0d want 20", cnt[0 +: CW]); end
    endtask

    task automatic test_clear();
        pulse_clear();
        id_x = 2'd0; id_y = 1'd0;
        valid = 12'h200;
        repeat (7) tick();
        n_cmp++; if (cnt[3*CW +: CW] !== 16'd7) begin n_bad++; $display("FAIL clr_pre got %0d want 7", cnt[3*CW +: CW]); end
        clear = 1'b1;
        tick();
        clear = 1'b0; valid = '0;
        n_cmp++; if (cnt[3*CW +: CW] !== 16'd0 || err !== 4'b0 || irq !== 1'b0) begin n_bad++; $display("FAIL clr_win got cnt=%0d err=%b irq=%b want 0", cnt[3*CW +: CW], err, irq); end
        tick();
        n_cmp++; if (cnt !== '0 || irq !== 1'b0) begin n_bad++; $display("FAIL clr_hold got cnt=%h irq=%b want 0", cnt, irq); end
    endtask

    task automatic test_capture();
        pulse_clear();
        id_x = 2'd0; id_y = 1'd0;
        flit = '0;
        flit[8*FW +: FW] = 64'hA5;
        flit[9*FW +: FW] = 64'h3C;
        valid = 12'h300;
        tick();
        valid = '0;
        n_cmp++; if (cnt[2*CW +: CW] !== 16'd1 || cnt[3*CW +: CW] !== 16'd1) begin n_bad++; $display("FAIL cap_cnt got S=%0d W=%0d want 1/1", cnt[2*CW +: CW], cnt[3*CW +: CW]); end
`ifdef PB_EDGE_SINK_HDR_CAPTURE_EN
        n_cmp++; if (hdr_vld !== 1'b1 || hdr_dir !== 2'd2 || hdr !== 64'hA5) begin n_bad++; $display("FAIL cap_first got vld=%b dir=%0d hdr=%h want 1/2/a5", hdr_vld, hdr_dir, hdr); end
        flit[9*FW +: FW] = 64'h77;
        valid = 12'h200;
        tick();
        valid = '0;
        n_cmp++; if (hdr_vld !== 1'b1 || hdr_dir !== 2'd2 || hdr !== 64'hA5) begin n_bad++; $display("FAIL cap_frozen got vld=%b dir=%0d hdr=%h want 1/2/a5", hdr_vld, hdr_dir, hdr); end
        pulse_clear();
        n_cmp++; if (hdr_vld !== 1'b0 || hdr !== '0) begin n_bad++; $display("FAIL cap_clear got vld=%b hdr=%h want 0/0", hdr_vld, hdr); end
`else
        n_cmp++; if (hdr_vld !== 1'b0 || hdr_dir !== 2'd0 || hdr !== '0) begin n_bad++; $display("FAIL cap_off got vld=%b dir=%0d hdr=%h want zeros", hdr_vld, hdr_dir, hdr); end
`endif
        flit = '0;
    endtask

    task automatic test_reset_mid();
        pulse_clear();
        id_x = 2'd0; id_y = 1'd0;
        valid = 12'h200;
        repeat (3) tick();
        n_cmp++; if (cnt[3*CW +: CW] !== 16'd3) begin n_bad++; $display("FAIL rmid_pre got %0d want 3", cnt[3*CW +: CW]); end
        rst_ni = 1'b0; #1;
        n_cmp++; if (ready !== '0) begin n_bad++; $display("FAIL rmid_ready got %h want 000", ready); end
        tick(); tick();
        n_cmp++; if (cnt !== '0 || err !== 4'b0 || irq !== 1'b0 || hdr_vld !== 1'b0 || hdr !== '0) begin n_bad++; $display("FAIL rmid_zero got cnt=%h err=%b irq=%b vld=%b", cnt, err, irq, hdr_vld); end
        rst_ni = 1'b1; #1;
        n_cmp++; if (ready !== 12'hFC0) begin n_bad++; $display("FAIL rmid_ready_rel got %h want fc0", ready); end
        tick();
        valid = '0;
        n_cmp++; if (cnt[3*CW +: CW] !== 16'd1 || irq !== 1'b1) begin n_bad++; $display("FAIL rmid_restart got %0d irq=%b want 1/1", cnt[3*CW +: CW], irq); end
    endtask

    initial begin
        rst_ni = 1'b0; clear = 1'b0; valid = '0; flit = '0; id_x = '0; id_y = '0;
        test_reset();
        test_corner00();
        test_mid();
        test_north();
        test_saturate();
        test_clear();
        test_capture();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/pb_mesh_edge_sink.md
PB_MESH_EDGE_SINK -- requirements
Module: pb_mesh_edge_sink

Interface
REQ-001 SHALL have parameter NumXMesh, default 3, mesh columns.
REQ-002 SHALL have parameter NumYMesh, default 2, mesh rows.
REQ-003 SHALL have parameter NumChan, default 3, physical channels per direction (req/rsp/wide).
REQ-004 SHALL have parameter FlitWidth, default 64, flit payload bits.
REQ-005 SHALL have parameter CntWidth, default 16, per-direction drop-counter width.
REQ-006 SHALL have port clk_i, input, 1, single clock; all state on its rising edge.
REQ-007 SHALL have port rst_ni, input, 1, reset, synchronous and active-low.
REQ-008 SHALL have port id_x_i, input, $clog2(NumXMesh), tile X coordinate; quasi-static.
REQ-009 SHALL have port id_y_i, input, $clog2(NumYMesh), tile Y coordinate; quasi-static.
REQ-010 SHALL have port valid_i, input, 4*NumChan, incoming flit valid; index dir*NumChan+chan, dir North=0, East=1, South=2, West=3.
REQ-011 SHALL have port ready_o, output, 4*NumChan, incoming flit ready.
REQ-012 SHALL have port flit_i, input, 4*NumChan*FlitWidth, incoming flits, same indexing.
REQ-013 SHALL have port clear_i, input, 1, synchronous clear of counters, sticky flags and capture.
REQ-014 SHALL have port cnt_o, output, 4*CntWidth, per-direction dropped-flit count.
REQ-015 SHALL have port err_dir_o, output, 4, sticky per-direction drop flag.
REQ-016 SHALL have port irq_o, output, 1, OR of err_dir_o.
REQ-017 SHALL have ports hdr_o (output, FlitWidth), hdr_dir_o (output, 2) and hdr_vld_o (output, 1): first-dropped-flit capture.

Function
REQ-018 SHALL compute a direction as tie-off when (x==0, West), (x==NumXMesh-1, East), (y==0, South) or (y==NumYMesh-1, North); mask recomputed from id_x_i/id_y_i every cycle.
REQ-019 SHALL drive ready_o=1 on every lane of a tie-off direction and ready_o=0 on every non-tie-off lane, combinationally from the mask while not in reset.
REQ-020 SHALL treat a lane as fired when valid_i & ready_o; fired flits are discarded.
REQ-021 SHALL add, per direction, the popcount of fired lanes (0..NumChan) to that direction's counter, updated and visible the cycle after the fire.
REQ-022 SHALL saturate each counter at 2^CntWidth-1; no wrap-around.
REQ-023 SHALL set err_dir_o[d] the cycle after any fire on direction d and hold it until clear or reset.
REQ-024 SHALL drive irq_o as OR of err_dir_o, same cycle as err_dir_o (registered, one-cycle latency from fire).
REQ-025 SHALL, on clear_i=1, zero all counters, err_dir_o and hdr_vld_o next cycle; clear wins over simultaneous fires, which are not counted or captured.
REQ-026 SHALL ignore valid_i on non-tie-off lanes: no count, no flag, no capture.
REQ-027 SHALL treat id_x_i/id_y_i changes as effective the same cycle for ready_o; already-accumulated state is unaffected.

Reset
REQ-028 SHALL, while rst_ni=0 at a clock edge, set cnt_o=0, err_dir_o=0, irq_o=0, hdr_vld_o=0, hdr_o=0, hdr_dir_o=0.
REQ-029 SHALL drive ready_o=0 on all lanes while rst_ni=0; flits presented during reset are not accepted or counted.
REQ-030 SHALL resume counting from zero on the first edge with rst_ni=1, including after reset asserted mid-operation.

Configuration
REQ-031 SHALL compile header capture only when macro PB_EDGE_SINK_HDR_CAPTURE_EN is defined.
REQ-032 SHALL, with the macro, latch hdr_o/hdr_dir_o and set hdr_vld_o on the first fire while hdr_vld_o=0; simultaneous fires pick lowest direction, then lowest channel; capture frozen until clear/reset.
REQ-033 SHALL, without the macro, tie hdr_o=0, hdr_dir_o=0, hdr_vld_o=0 and instantiate no capture registers.

Verification
REQ-034 SHALL cover: id=(0,0), West ch0 valid 5 cycles -> ready_o West/South lanes=1, cnt_o[West]=5, irq_o=1 from cycle after first fire.
REQ-035 SHALL cover: id=(1,0), East ch1 valid 4 cycles -> ready_o East=0, cnt_o all 0, irq_o=0.
REQ-036 SHALL cover: id=(2,1), North ch0..2 all valid one cycle -> cnt_o[North]=3; CntWidth=4 with 20 single-lane fires -> 15.
REQ-037 SHALL cover: clear_i=1 same cycle as West fire after count 7 -> next cycle cnt_o[West]=0, err_dir_o=0, irq_o=0.
REQ-038 SHALL cover (macro defined): id=(0,0), South ch2 flit 0xA5 and West ch0 flit 0x3C same cycle -> hdr_dir_o=2, hdr_o=0xA5, hdr_vld_o=1; later fires leave it unchanged.
REQ-039 SHALL cover: rst_ni=0 for 2 cycles mid-stream with valid held -> ready_o=0, all outputs 0, counting restarts at 1 after release.
